frv_mem_responder: RTL

- Memory-side responder for the core's req/gnt + recv/ack memory interface, i.e. the far end of the fetch stage's instruction bus.
- Backs a word-addressed RAM and accepts pipelined requests; returns responses strictly in order through a bounded response queue.
- Used as the instruction/data memory model in core-level simulation and as the on-chip scratch memory slave.

---
 rtl/frv_mem_responder_if.sv | 26 ++
 rtl/frv_mem_responder.sv | 109 ++++++++++
 2 files changed

// File: rtl/frv_mem_responder_if.sv
// Memory request/response bus between a core initiator and a memory responder.
// Requests use a req/gnt handshake, responses use a recv/ack handshake.
interface frv_mem_responder_if;
    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    // Initiator side: drives requests and consumes responses.
    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    // Responder side: grants requests and produces responses.
    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/frv_mem_responder.sv
// Word-addressed RAM responder for the core memory bus.
// Requests are decoded and executed at the accept edge; the result is parked in
// a small in-order response queue that the initiator drains with recv/ack.
module frv_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 cfg_stall,
    frv_mem_responder_if.slave   mem
);

    localparam int                IDX_W    = $clog2(DEPTH_WORDS);
    localparam int                PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int                OCC_W    = $clog2(RSP_DEPTH + 1);
    localparam logic [32:0]       SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(RSP_DEPTH - 1);
    localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(RSP_DEPTH);

    logic [31:0]      ramMem    [DEPTH_WORDS];
    logic [31:0]      rspData_q [RSP_DEPTH];
    logic             rspErr_q  [RSP_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [31:0]      addrOffset;
    logic [IDX_W-1:0] wordIdx;
    logic             addrErr;
    logic             grantOk;
    logic             rspValid;
    logic             accept;
    logic             consume;
    logic [31:0]      acceptData;

    // Decode the presented request and derive the handshake qualifiers.
    // Grant looks only at registered occupancy, so a consume in the same cycle
    // cannot open a slot until the following cycle.
    always_comb begin
        addrOffset = mem.mem_addr - BASE_ADDR;
        wordIdx    = addrOffset[IDX_W+1:2];
        addrErr    = (mem.mem_addr[1:0] != 2'b00)
                   || (mem.mem_addr < BASE_ADDR)
                   || ({1'b0, addrOffset} >= SPAN);
        grantOk    = !cfg_stall && (occ_q < FULL_OCC);
        rspValid   = (occ_q != '0);
        accept     = mem.mem_req && grantOk;
        consume    = rspValid && mem.mem_ack;
        acceptData = (addrErr || mem.mem_wen) ? 32'h0 : ramMem[wordIdx];
    end

    assign mem.mem_gnt   = grantOk;
    assign mem.mem_recv  = rspValid;
    assign mem.mem_rdata = rspValid ? rspData_q[head_q] : 32'h0;
    assign mem.mem_error = rspValid ? rspErr_q[head_q]  : 1'b0;

    // Next-state pointers and occupancy; accept and consume may coincide.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (accept) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end
        if (consume) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end
        if (accept && !consume) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && consume) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Byte-strobed RAM write at accept; contents deliberately survive reset.
    always_ff @(posedge g_clk) begin
        if (!g_reset && accept && mem.mem_wen && !addrErr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.mem_strb[b]) begin
                    ramMem[wordIdx][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue: capture the result at accept, advance head on consume.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rspData_q[i] <= 32'h0;
                rspErr_q[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                rspData_q[tail_q] <= acceptData;
                rspErr_q[tail_q]  <= addrErr;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule
